// File: rtl/fdew_pipe.sv
// Four-stage in-order pipeline (IF, ID, EX, WB) with a 16-entry register file and branch/HALT flush.
// Define FDEW_FORWARD_EN for an EX/WB->EX forwarding path; otherwise ID interlocks on hazards.
module fdew_pipe #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_data,
    output logic              wb_valid,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted
);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LUI  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LUI);
    endfunction

    function automatic logic signed [DATA_W-1:0] alu(
        input logic [3:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] imm
    );
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ADDI: return a + imm;
            OP_LUI:  return imm;
            default: return '0;
        endcase
    endfunction

    logic [PC_W-1:0] pc;
    logic            halted_q;

    logic            vld_p0;
    logic [31:0]     instr_p0;
    logic [PC_W-1:0] pc_p0;

    logic                     vld_p1;
    logic                     wr_p1;
    logic [3:0]               op_p1;
    logic [3:0]               rd_p1;
    logic signed [DATA_W-1:0] a_p1;
    logic signed [DATA_W-1:0] b_p1;
    logic signed [15:0]       imm16_p1;
    logic [PC_W-1:0]          pc_p1;
`ifdef FDEW_FORWARD_EN
    logic [3:0]               rs_p1;
    logic [3:0]               rt_p1;
`endif

    logic                     vld_p2;
    logic                     wr_p2;
    logic [3:0]               rd_p2;
    logic signed [DATA_W-1:0] res_p2;

    logic signed [DATA_W-1:0] rf [16];

    logic wb_we;
    assign wb_we = vld_p2 && wr_p2 && (rd_p2 != 4'd0);

    // ---- IF/ID -> ID: decode and register read with write-through ----
    logic [3:0]               id_op;
    logic [3:0]               id_rd;
    logic [3:0]               id_rs;
    logic [3:0]               id_rt;
    logic signed [DATA_W-1:0] id_a;
    logic signed [DATA_W-1:0] id_b;
    logic                     stall;

    assign id_op = instr_p0[31:28];
    assign id_rd = instr_p0[27:24];
    assign id_rs = instr_p0[23:20];
    assign id_rt = instr_p0[19:16];

    always_comb begin
        id_a = rf[id_rs];
        id_b = rf[id_rt];
        if (wb_we && rd_p2 == id_rs) id_a = res_p2;
        if (wb_we && rd_p2 == id_rt) id_b = res_p2;
        if (id_rs == 4'd0) id_a = '0;
        if (id_rt == 4'd0) id_b = '0;
    end

`ifdef FDEW_FORWARD_EN
    assign stall = 1'b0;
`else
    function automatic logic uses_rs(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_ADDI)) || (op == OP_BEQ);
    endfunction

    function automatic logic uses_rt(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_BEQ);
    endfunction

    // The producer in ID/EX is one cycle from WB, where write-through picks it up.
    assign stall = vld_p0 && vld_p1 && wr_p1 && (rd_p1 != 4'd0) &&
                   ((uses_rs(id_op) && id_rs == rd_p1) ||
                    (uses_rt(id_op) && id_rt == rd_p1));
`endif

    // ---- ID/EX -> EX: operand select, ALU, branch compare ----
    logic signed [DATA_W-1:0] ex_a;
    logic signed [DATA_W-1:0] ex_b;
    logic signed [DATA_W-1:0] imm_ex;
    logic signed [DATA_W-1:0] ex_res;
    logic [PC_W-1:0]          br_target;
    logic                     br_taken;
    logic                     halt_ex;

    always_comb begin
        ex_a = a_p1;
        ex_b = b_p1;
`ifdef FDEW_FORWARD_EN
        if (wb_we && rd_p2 == rs_p1) ex_a = res_p2;
        if (wb_we && rd_p2 == rt_p1) ex_b = res_p2;
`endif
    end

    always_comb begin
        if (op_p1 == OP_LUI) imm_ex = DATA_W'(imm16_p1) << (DATA_W - 16);
        else                 imm_ex = DATA_W'(imm16_p1);
    end

    assign ex_res    = alu(op_p1, ex_a, ex_b, imm_ex);
    assign br_target = pc_p1 + PC_W'(1) + PC_W'(imm16_p1);
    assign br_taken  = vld_p1 && (op_p1 == OP_BEQ) && (ex_a == ex_b);
    assign halt_ex   = vld_p1 && (op_p1 == OP_HALT);

    // ---- control: PC, valid bits, halt ----
    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= PC_W'(RESET_PC);
            halted_q <= 1'b0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            wr_p2    <= 1'b0;
            rd_p2    <= 4'd0;
            res_p2   <= '0;
        end else if (run_en) begin
            vld_p2 <= vld_p1;
            wr_p2  <= vld_p1 && wr_p1;
            rd_p2  <= rd_p1;
            res_p2 <= ex_res;
            if (halt_ex || halted_q) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
                if (halt_ex) halted_q <= 1'b1;
            end else if (br_taken) begin
                pc     <= br_target;
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
            end else if (stall) begin
                vld_p1 <= 1'b0;
            end else begin
                pc     <= pc + PC_W'(1);
                vld_p0 <= 1'b1;
                vld_p1 <= vld_p0;
            end
        end
    end

    // ---- IF -> IF/ID and ID -> ID/EX data, qualified by the valid bits above ----
    always_ff @(posedge clock) begin
        if (run_en) begin
            if (!stall) begin
                instr_p0 <= imem_data;
                pc_p0    <= pc;
            end
            op_p1    <= id_op;
            rd_p1    <= id_rd;
            wr_p1    <= writes_rd(id_op);
            a_p1     <= id_a;
            b_p1     <= id_b;
            imm16_p1 <= $signed(instr_p0[15:0]);
            pc_p1    <= pc_p0;
`ifdef FDEW_FORWARD_EN
            rs_p1    <= id_rs;
            rt_p1    <= id_rt;
`endif
        end
    end

    // ---- EX/WB -> register file ----
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_valid) begin
            rf[rd_p2] <= res_p2;
        end
    end

    assign wb_valid  = wb_we && run_en;
    assign wb_rd     = rd_p2;
    assign wb_data   = res_p2;
    assign imem_addr = pc;
    assign halted    = halted_q;

endmodule
